// File: rtl/quad_demux_1to2_pkg.sv
// Shared types for the quad 1-to-2 demux.
// Pair FSM encoding and channel select values.
package quad_demux_1to2_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    GOT_A = 2'b01,
    GOT_B = 2'b10
  } pair_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux_capture_reg.sv
// Enable-loaded holding register.
// Valid pulses for the cycle after each load.
module demux_capture_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_load;
      if (i_load) begin
        r_q <= i_d;
      end
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

endmodule

// File: rtl/quad_demux_1to2.sv
// Registered 1-to-2 demux with A/B pairing,
// pair counter and overrun detection.
module quad_demux_1to2
  import quad_demux_1to2_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] Y,
  input  logic             S,
  input  logic             E,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             A_valid,
  output logic             B_valid,
  output logic             pair_valid,
  output logic             overrun,
  output logic             err,
  output logic [CNT_W-1:0] pair_count
);

  logic        w_cap_a;
  logic        w_cap_b;
  pair_state_e r_state;
  logic        r_pair_valid;
  logic        r_overrun;
  logic        r_err;
  logic [CNT_W-1:0] r_count;

  assign w_cap_a = !E && (S == SEL_A);
  assign w_cap_b = !E && (S == SEL_B);

  demux_capture_reg #(.WIDTH(WIDTH)) u_cap_a (
    .clock   (clock),
    .reset_b (reset_b),
    .i_load  (w_cap_a),
    .i_d     (Y),
    .o_q     (A),
    .o_valid (A_valid)
  );

  demux_capture_reg #(.WIDTH(WIDTH)) u_cap_b (
    .clock   (clock),
    .reset_b (reset_b),
    .i_load  (w_cap_b),
    .i_d     (Y),
    .o_q     (B),
    .o_valid (B_valid)
  );

  // Pulses are registered alongside the captures so they line up.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      r_state      <= EMPTY;
      r_pair_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_err        <= 1'b0;
      r_count      <= '0;
    end else begin
      r_pair_valid <= 1'b0;
      r_overrun    <= 1'b0;
      unique case (r_state)
        EMPTY: begin
          if (w_cap_a) r_state <= GOT_A;
          else if (w_cap_b) r_state <= GOT_B;
        end
        GOT_A: begin
          if (w_cap_b) begin
            r_state      <= EMPTY;
            r_pair_valid <= 1'b1;
            r_count      <= r_count + 1'b1;
          end else if (w_cap_a) begin
            r_overrun <= 1'b1;
            r_err     <= 1'b1;
          end
        end
        GOT_B: begin
          if (w_cap_a) begin
            r_state      <= EMPTY;
            r_pair_valid <= 1'b1;
            r_count      <= r_count + 1'b1;
          end else if (w_cap_b) begin
            r_overrun <= 1'b1;
            r_err     <= 1'b1;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign pair_valid = r_pair_valid;
  assign overrun    = r_overrun;
  assign err        = r_err;
  assign pair_count = r_count;

endmodule
